// File: rtl/up_bus_pkg.sv
// up_bus_pkg: shared constants, state encoding and helpers for the CPU register-bus bridge.
package up_bus_pkg;

   localparam int UP_DW       = 32;
   localparam int ERR_W       = 3;
   localparam int ERR_DECODE  = 0;
   localparam int ERR_OVERRUN = 1;
   localparam int ERR_TIMEOUT = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } up_state_e;

   // Address mask that zeroes the top sel_w bits (the port index field).
   function automatic logic [UP_DW-1:0] sel_clear_mask(input int sel_w);
      logic [UP_DW-1:0] m;
      for (int i = 0; i < UP_DW; i++) begin
         m[i] = (i < UP_DW - sel_w);
      end
      return m;
   endfunction

endpackage

// File: rtl/up_timeout_cnt.sv
// up_timeout_cnt: loadable down-counter; expired is high while the count sits at 1,
// i.e. on the CYCLES-th decrement-enabled cycle after a load.
module up_timeout_cnt
   import up_bus_pkg::*;
#(
   parameter int CYCLES = 1024
) (
   input  logic up_clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic expired
);

   localparam int CW = $clog2(CYCLES + 1);

   logic [CW-1:0] cnt_reg;

   // Reload on each new access, count down while the slave stays busy.
   always_ff @(posedge up_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= CW'(CYCLES);
      end else if (dec && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign expired = (cnt_reg == CW'(1));

endmodule

// File: rtl/up_port_bridge.sv
// up_port_bridge: splits the CPU register bus onto per-port slaves, one access at a time.
// The top PORT_SEL_W address bits pick the slave; slave busy/read data merge back into
// up_wait/up_data_rd. Sticky error flags {timeout, overrun, decode} are cleared by err_clr.
// Optional feature: define UP_BRIDGE_TIMEOUT_EN to abort accesses whose slave stays busy
// for TIMEOUT_CYCLES cycles; without it WAIT is unbounded and err_flags[2] reads 0.
module up_port_bridge
   import up_bus_pkg::*;
#(
   parameter int               NUM_PORTS      = 2,
   parameter int               PORT_SEL_W     = 1,
   parameter int               TIMEOUT_CYCLES = 1024,
   parameter logic [UP_DW-1:0] BAD_DATA       = 32'hDEADBEEF
) (
   input  logic                       up_clk,
   input  logic                       rst_n,
   input  logic                       up_wr,
   input  logic                       up_rd,
   input  logic [UP_DW-1:0]           up_addr,
   input  logic [UP_DW-1:0]           up_data_wr,
   output logic [UP_DW-1:0]           up_data_rd,
   output logic                       up_wait,
   output logic [NUM_PORTS-1:0]       s_cs,
   output logic                       s_wr,
   output logic                       s_rd,
   output logic [UP_DW-1:0]           s_addr,
   output logic [UP_DW-1:0]           s_data_wr,
   input  logic [UP_DW*NUM_PORTS-1:0] s_data_rd,
   input  logic [NUM_PORTS-1:0]       s_busy,
   input  logic                       err_clr,
   output logic [ERR_W-1:0]           err_flags
);

   localparam logic [UP_DW-1:0]    ADDR_MASK   = sel_clear_mask(PORT_SEL_W);
   localparam logic [PORT_SEL_W:0] NUM_PORTS_L = (PORT_SEL_W + 1)'(NUM_PORTS);

   up_state_e            state_reg;
   logic [NUM_PORTS-1:0] s_cs_reg;
   logic                 s_wr_reg;
   logic                 s_rd_reg;
   logic                 up_wait_reg;
   logic                 is_wr_reg;
   logic                 valid_reg;
   logic [UP_DW-1:0]     s_addr_reg;
   logic [UP_DW-1:0]     s_data_wr_reg;
   logic [UP_DW-1:0]     up_data_rd_reg;
   logic [ERR_W-1:0]     err_reg;
   logic [ERR_W-1:0]     err_set;

   logic                  strobe;
   logic                  addr_valid;
   logic                  busy_sel;
   logic                  timeout_hit;
   logic [PORT_SEL_W-1:0] sel_idx;
   logic [NUM_PORTS-1:0]  cs_onehot;
   logic [UP_DW-1:0]      rd_masked [NUM_PORTS];
   logic [UP_DW-1:0]      rd_sel;

   assign strobe     = up_wr | up_rd;
   assign sel_idx    = up_addr[UP_DW-1 -: PORT_SEL_W];
   assign addr_valid = ({1'b0, sel_idx} < NUM_PORTS_L);

   // The latched one-hot select steers busy and read data; an undecoded access has no
   // select bit, so it never sees busy and completes on the first WAIT cycle.
   assign busy_sel = |(s_busy & s_cs_reg);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         localparam logic [PORT_SEL_W-1:0] PORT_ID = PORT_SEL_W'(gi);
         assign cs_onehot[gi] = addr_valid && (sel_idx == PORT_ID);
         assign rd_masked[gi] = s_data_rd[UP_DW*gi +: UP_DW] & {UP_DW{s_cs_reg[gi]}};
      end
   endgenerate

   // AND-OR read-data mux over the selected port.
   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         rd_sel = rd_sel | rd_masked[i];
      end
   end

`ifdef UP_BRIDGE_TIMEOUT_EN
   logic tmo_expired;

   up_timeout_cnt #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .up_clk  (up_clk),
      .rst_n   (rst_n),
      .load    (state_reg == ISSUE),
      .dec     ((state_reg == WAIT) && busy_sel),
      .expired (tmo_expired)
   );

   assign timeout_hit = (state_reg == WAIT) && busy_sel && tmo_expired;
`else
   // Timeout compiled out: this term is constant 0 for any legal TIMEOUT_CYCLES.
   assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

   // Error events raised this cycle.
   always_comb begin
      err_set              = '0;
      err_set[ERR_DECODE]  = (state_reg == IDLE) && strobe && !addr_valid;
      err_set[ERR_OVERRUN] = (state_reg != IDLE) && strobe;
      err_set[ERR_TIMEOUT] = timeout_hit;
   end

   // Sticky error flags; a new event in the clear cycle survives the clear.
   always_ff @(posedge up_clk or negedge rst_n) begin
      if (!rst_n) begin
         err_reg <= '0;
      end else if (err_clr) begin
         err_reg <= err_set;
      end else begin
         err_reg <= err_reg | err_set;
      end
   end

   // Transaction FSM with registered bus outputs.
   always_ff @(posedge up_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         s_cs_reg       <= '0;
         s_wr_reg       <= 1'b0;
         s_rd_reg       <= 1'b0;
         up_wait_reg    <= 1'b0;
         is_wr_reg      <= 1'b0;
         valid_reg      <= 1'b0;
         s_addr_reg     <= '0;
         s_data_wr_reg  <= '0;
         up_data_rd_reg <= '0;
      end else begin
         s_wr_reg <= 1'b0;
         s_rd_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (strobe) begin
                  // A write wins when both strobes arrive together.
                  is_wr_reg     <= up_wr;
                  valid_reg     <= addr_valid;
                  s_addr_reg    <= up_addr & ADDR_MASK;
                  s_data_wr_reg <= up_data_wr;
                  s_cs_reg      <= cs_onehot;
                  s_wr_reg      <= up_wr & addr_valid;
                  s_rd_reg      <= ~up_wr & addr_valid;
                  up_wait_reg   <= 1'b1;
                  state_reg     <= ISSUE;
               end
            end
            ISSUE: begin
               state_reg <= WAIT;
            end
            WAIT: begin
               if (!busy_sel || timeout_hit) begin
                  if (!is_wr_reg) begin
                     up_data_rd_reg <= (valid_reg && !busy_sel) ? rd_sel : BAD_DATA;
                  end
                  s_cs_reg    <= '0;
                  up_wait_reg <= 1'b0;
                  state_reg   <= IDLE;
               end
            end
            default: begin
               s_cs_reg    <= '0;
               up_wait_reg <= 1'b0;
               state_reg   <= IDLE;
            end
         endcase
      end
   end

   assign up_data_rd = up_data_rd_reg;
   assign up_wait    = up_wait_reg;
   assign s_cs       = s_cs_reg;
   assign s_wr       = s_wr_reg;
   assign s_rd       = s_rd_reg;
   assign s_addr     = s_addr_reg;
   assign s_data_wr  = s_data_wr_reg;
   assign err_flags  = err_reg;

endmodule

// File: tb/tb_up_port_bridge.sv
// tb_up_port_bridge: directed, table-driven bench for up_port_bridge.
// dut_a: 2 ports / 1 select bit; dut_b: 3 ports / 2 select bits. Both use TIMEOUT_CYCLES=16;
// the timeout sequence runs only when UP_BRIDGE_TIMEOUT_EN is defined.
module tb_up_port_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr = 1'b0;
   logic        rd = 1'b0;
   logic        err_clr = 1'b0;
   logic        sel = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [2:0]  busy_v = '0;
   logic [95:0] drd_v = '0;

   always #5 clk = ~clk;

   logic [31:0] a_rd, a_saddr, a_sdwr;
   logic        a_wait, a_swr, a_srd;
   logic [1:0]  a_cs;
   logic [2:0]  a_err;
   logic [31:0] b_rd, b_saddr, b_sdwr;
   logic        b_wait, b_swr, b_srd;
   logic [2:0]  b_cs;
   logic [2:0]  b_err;

   up_port_bridge #(
      .NUM_PORTS(2), .PORT_SEL_W(1), .TIMEOUT_CYCLES(16), .BAD_DATA(32'hDEADBEEF)
   ) dut_a (
      .up_clk(clk), .rst_n(rst_n), .up_wr(wr & ~sel), .up_rd(rd & ~sel),
      .up_addr(addr), .up_data_wr(wdata), .up_data_rd(a_rd), .up_wait(a_wait),
      .s_cs(a_cs), .s_wr(a_swr), .s_rd(a_srd), .s_addr(a_saddr), .s_data_wr(a_sdwr),
      .s_data_rd(drd_v[63:0]), .s_busy(busy_v[1:0]), .err_clr(err_clr), .err_flags(a_err)
   );

   up_port_bridge #(
      .NUM_PORTS(3), .PORT_SEL_W(2), .TIMEOUT_CYCLES(16), .BAD_DATA(32'hDEADBEEF)
   ) dut_b (
      .up_clk(clk), .rst_n(rst_n), .up_wr(wr & sel), .up_rd(rd & sel),
      .up_addr(addr), .up_data_wr(wdata), .up_data_rd(b_rd), .up_wait(b_wait),
      .s_cs(b_cs), .s_wr(b_swr), .s_rd(b_srd), .s_addr(b_saddr), .s_data_wr(b_sdwr),
      .s_data_rd(drd_v), .s_busy(busy_v), .err_clr(err_clr), .err_flags(b_err)
   );

   // Outputs of the instance currently under test.
   logic [2:0]  cur_cs, cur_err;
   logic        cur_wait, cur_swr, cur_srd;
   logic [31:0] cur_rd, cur_saddr, cur_sdwr;

   always_comb begin
      if (sel) begin
         cur_cs = b_cs;  cur_err = b_err; cur_wait = b_wait; cur_swr = b_swr;
         cur_srd = b_srd; cur_rd = b_rd; cur_saddr = b_saddr; cur_sdwr = b_sdwr;
      end else begin
         cur_cs = {1'b0, a_cs}; cur_err = a_err; cur_wait = a_wait; cur_swr = a_swr;
         cur_srd = a_srd; cur_rd = a_rd; cur_saddr = a_saddr; cur_sdwr = a_sdwr;
      end
   end

   typedef struct {
      logic        sel;
      logic        wr;
      logic        rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  busy_mask;
      int          busy_cyc;   // WAIT cycles the slave stays busy
      logic [95:0] drd;        // {port2, port1, port0}
      int          ovr_cyc;    // cycle after the strobe to inject a second strobe (0 = none)
      logic        ovr_clr;    // pulse err_clr together with that second strobe
      logic [2:0]  exp_cs;
      logic        exp_swr;
      logic        exp_srd;
      logic [31:0] exp_saddr;
      int          exp_lat;    // strobe cycle T to first cycle with up_wait low
      logic [31:0] exp_rd;
      logic [2:0]  exp_err;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic run_txn(input vec_t v, input int num);
      int lat;
      bit done;
      bit hold_bad;
      lat = 0;
      done = 1'b0;
      hold_bad = 1'b0;
      sel = v.sel;
      // Start each transaction from clear flags.
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("err_clr", 96'(cur_err), 96'(3'b000));
      wr = v.wr;
      rd = v.rd;
      addr = v.addr;
      wdata = v.wdata;
      drd_v = v.drd;
      busy_v = v.busy_mask;
      for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            wr = 1'b0;
            rd = 1'b0;
            check("issue_s_cs", 96'(cur_cs), 96'(v.exp_cs));
            check("issue_s_wr", 96'(cur_swr), 96'(v.exp_swr));
            check("issue_s_rd", 96'(cur_srd), 96'(v.exp_srd));
            check("issue_s_addr", 96'(cur_saddr), 96'(v.exp_saddr));
            check("issue_s_data_wr", 96'(cur_sdwr), 96'(v.wdata));
            check("issue_up_wait", 96'(cur_wait), 96'(1'b1));
         end else begin
            if (!cur_wait) begin
               done = 1'b1;
               lat = cyc;
            end else if ((cur_cs !== v.exp_cs) || cur_swr || cur_srd) begin
               hold_bad = 1'b1;
            end
         end
         if (cyc == v.ovr_cyc) begin
            wr = 1'b1;
            addr = 32'h0;
            wdata = 32'h0BAD0BAD;
            err_clr = v.ovr_clr;
         end else if (cyc == v.ovr_cyc + 1) begin
            wr = 1'b0;
            err_clr = 1'b0;
         end
         busy_v = (cyc <= v.busy_cyc + 1) ? v.busy_mask : 3'b000;
      end
      check("latency", 96'(lat), 96'(v.exp_lat));
      check("wait_hold", 96'(hold_bad), 96'(1'b0));
      check("up_data_rd", 96'(cur_rd), 96'(v.exp_rd));
      check("err_flags", 96'(cur_err), 96'(v.exp_err));
      check("done_s_cs", 96'(cur_cs), 96'(3'b000));
      check("done_s_addr", 96'(cur_saddr), 96'(v.exp_saddr));
      @(negedge clk);
      busy_v = 3'b000;
      check("idle_up_wait", 96'(cur_wait), 96'(1'b0));
      check("idle_no_strobe", 96'({cur_swr, cur_srd}), 96'(2'b00));
      $display("[TB] txn %0d sel=%0d addr=%08h lat=%0d up_data_rd=%08h err_flags=%03b",
               num, v.sel, v.addr, lat, cur_rd, cur_err);
   endtask

   vec_t vecs [13];
   vec_t rv;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //          sel   wr    rd    addr           wdata          mask    B     drd                                          ovr  clr   cs      swr   srd   saddr          lat  rd             err
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'hA5A5_0001, 3'b001, 0,  {32'h0, 32'h1111_1111, 32'h2222_2222},       0, 1'b0, 3'b001, 1'b1, 1'b0, 32'h0000_0010, 3,  32'h0000_0000, 3'b000};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h8000_0004, 32'h0,         3'b010, 5,  {32'h0, 32'h1234_5678, 32'h0BAD_0000},       0, 1'b0, 3'b010, 1'b0, 1'b1, 32'h0000_0004, 8,  32'h1234_5678, 3'b000};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0100, 32'h55AA_33CC, 3'b010, 2,  {32'h0, 32'h9999_9999, 32'h8888_8888},       0, 1'b0, 3'b010, 1'b1, 1'b0, 32'h0000_0100, 5,  32'h1234_5678, 3'b000};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h0,         3'b001, 0,  {32'h0, 32'hFFFF_0000, 32'hCAFE_F00D},       0, 1'b0, 3'b001, 1'b0, 1'b1, 32'h0000_0020, 3,  32'hCAFE_F00D, 3'b000};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h7FFF_FFFC, 32'h0,         3'b001, 1,  {32'h0, 32'hAAAA_AAAA, 32'h0102_0304},       0, 1'b0, 3'b001, 1'b0, 1'b1, 32'h7FFF_FFFC, 4,  32'h0102_0304, 3'b000};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h8000_0008, 32'h0000_BEEF, 3'b010, 0,  {32'h0, 32'h4444_4444, 32'h5555_5555},       0, 1'b0, 3'b010, 1'b1, 1'b0, 32'h0000_0008, 3,  32'h0102_0304, 3'b000};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h8000_000C, 32'h0,         3'b010, 4,  {32'h0, 32'h600D_600D, 32'h0},               3, 1'b0, 3'b010, 1'b0, 1'b1, 32'h0000_000C, 7,  32'h600D_600D, 3'b010};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0030, 32'h0,         3'b001, 3,  {32'h0, 32'h0, 32'h7777_0030},               2, 1'b1, 3'b001, 1'b0, 1'b1, 32'h0000_0030, 6,  32'h7777_0030, 3'b010};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h8000_0010, 32'h0,         3'b010, 3,  {32'h0, 32'h1357_9BDF, 32'h0},               1, 1'b0, 3'b010, 1'b0, 1'b1, 32'h0000_0010, 6,  32'h1357_9BDF, 3'b010};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'hC000_0000, 32'h0,         3'b111, 10, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0000_0000, 3,  32'hDEAD_BEEF, 3'b001};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h8000_0040, 32'h0,         3'b100, 1,  {32'h89AB_CDEF, 32'h2222_2222, 32'h1111_1111}, 0, 1'b0, 3'b100, 1'b0, 1'b1, 32'h0000_0040, 4,  32'h89AB_CDEF, 3'b000};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 32'hC000_0010, 32'h1212_1212, 3'b000, 0,  {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0000_0010, 3,  32'h89AB_CDEF, 3'b001};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h4000_0000, 32'h0,         3'b010, 2,  {32'h3333_3333, 32'h0F0F_0F0F, 32'h1111_1111}, 0, 1'b0, 3'b010, 1'b0, 1'b1, 32'h0000_0000, 5,  32'h0F0F_0F0F, 3'b000};

      // Reset state of both instances.
      repeat (3) @(negedge clk);
      check("reset_a_up_data_rd", 96'(a_rd), 96'(32'h0));
      check("reset_a_up_wait", 96'(a_wait), 96'(1'b0));
      check("reset_a_s_cs", 96'(a_cs), 96'(2'b00));
      check("reset_a_strobes", 96'({a_swr, a_srd}), 96'(2'b00));
      check("reset_a_s_addr", 96'(a_saddr), 96'(32'h0));
      check("reset_a_err_flags", 96'(a_err), 96'(3'b000));
      check("reset_b_s_cs", 96'(b_cs), 96'(3'b000));
      check("reset_b_up_wait", 96'(b_wait), 96'(1'b0));
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         run_txn(vecs[i], i);
      end

`ifdef UP_BRIDGE_TIMEOUT_EN
      // Slave busy stuck high: abort after 16 WAIT cycles.
      rv = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0, 3'b001, 1000, {32'h0, 32'h0, 32'h7E57_7E57},
             0, 1'b0, 3'b001, 1'b0, 1'b1, 32'h0000_0000, 18, 32'hDEAD_BEEF, 3'b100};
      run_txn(rv, 100);
`endif

      // Asynchronous reset while dut_a waits on a busy slave.
      sel = 1'b0;
      @(negedge clk);
      rd = 1'b1;
      addr = 32'h8000_0020;
      busy_v = 3'b010;
      @(negedge clk);
      rd = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_s_cs", 96'(a_cs), 96'(2'b10));
      check("pre_reset_up_wait", 96'(a_wait), 96'(1'b1));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_s_cs", 96'(a_cs), 96'(2'b00));
      check("async_reset_up_wait", 96'(a_wait), 96'(1'b0));
      check("async_reset_up_data_rd", 96'(a_rd), 96'(32'h0));
      check("async_reset_err_flags", 96'(a_err), 96'(3'b000));
      @(negedge clk);
      rst_n = 1'b1;
      busy_v = 3'b000;
      rv = '{1'b0, 1'b0, 1'b1, 32'h8000_0024, 32'h0, 3'b010, 1, {32'h0, 32'h5A5A_5A5A, 32'h0},
             0, 1'b0, 3'b010, 1'b0, 1'b1, 32'h0000_0024, 4, 32'h5A5A_5A5A, 3'b000};
      run_txn(rv, 200);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
